// File: rtl/keypad_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared constants, data-bus word layout and width helper for the
//            keypad DMA peripheral.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int NO_KEY   = 0;
    localparam int DB_W     = 8;
    localparam int OVF_BIT  = 7;
    localparam int CODE_MSB = 6;
    localparam int CODE_LSB = 0;

    typedef struct packed {
        logic       ovf;
        logic [6:0] code;
    } db_word_t;

    function automatic int code_w(input int nkeys);
        return $clog2(nkeys + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_fifo.sv
// ============================================================================
// Module   : keypad_fifo
// Purpose  : Synchronous FIFO with wrap-bit pointers; pop-then-push when full.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             empty_next
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [c_aw:0]    w_wr_ptr_next;
    logic [c_aw:0]    w_rd_ptr_next;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    // A pop frees the slot first, so a push into a full queue still lands.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign w_wr_ptr_next = r_wr_ptr + (c_aw+1)'(w_do_push);
    assign w_rd_ptr_next = r_rd_ptr + (c_aw+1)'(w_do_pop);
    assign empty_next    = (w_wr_ptr_next == w_rd_ptr_next);

    assign dout = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/keypad_dma_ctrl.sv
// ============================================================================
// Module   : keypad_dma_ctrl
// Purpose  : Key synchroniser, debouncer and encoder feeding a press-event
//            FIFO that is drained over the DREQ/DACK handshake on DB.
//            Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_dma_ctrl
    import keypad_pkg::*;
#(
    parameter int NKEYS        = 8,
    parameter int DEB_CYCLES   = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 5000,
    parameter int REPEAT_RATE  = 1000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NKEYS-1:0] key,
    input  logic             IO_EN,
    input  logic             DACK,
    output logic             DREQ,
    inout  wire  [7:0]       DB,
    inout  wire  [3:0]       CB,
    inout  wire  [7:0]       AB
);

    localparam int c_code_w = code_w(NKEYS);
    localparam int c_deb_w  = $clog2(DEB_CYCLES + 1);

    logic [NKEYS-1:0]    r_key_s1;
    logic [NKEYS-1:0]    r_key_s2;
    logic [c_code_w-1:0] w_cand;
    logic                w_seen;
    logic                w_multi;
    logic [c_code_w-1:0] r_prev;
    logic [c_deb_w-1:0]  r_deb_cnt;
    logic [c_code_w-1:0] r_accepted;
    logic                w_stable;
    logic                w_acc_load;
    logic                w_press;
    logic                w_repeat;
    logic                w_push;
    logic [c_code_w-1:0] w_push_code;

    logic [c_code_w-1:0] w_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_empty_next;
    logic                w_pop;

    logic                w_rd;
    logic                r_rd_q;
    db_word_t            w_db_live;
    db_word_t            r_db_hold;
    db_word_t            w_db_out;
    logic                r_hold_valid;
    logic                r_ovf;
    logic                r_dreq;
    logic                w_unused_bus;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_key_s1 <= '0;
            r_key_s2 <= '0;
        end else begin
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
        end
    end

    // One-hot to code; no key or several keys both map to NO_KEY.
    always_comb begin
        w_cand  = c_code_w'(NO_KEY);
        w_seen  = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (r_key_s2[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen = 1'b1;
                w_cand = c_code_w'(i + 1);
            end
        end
        if (w_multi) begin
            w_cand = c_code_w'(NO_KEY);
        end
    end

    assign w_stable   = (w_cand == r_prev);
    assign w_acc_load = w_stable && (r_deb_cnt >= c_deb_w'(DEB_CYCLES - 1)) &&
                        (w_cand != r_accepted);
    assign w_press    = w_acc_load && (w_cand != c_code_w'(NO_KEY));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_prev     <= '0;
            r_deb_cnt  <= '0;
            r_accepted <= '0;
        end else begin
            r_prev <= w_cand;
            if (!w_stable) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt != c_deb_w'(DEB_CYCLES)) begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
            if (w_acc_load) begin
                r_accepted <= w_cand;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int c_rpt_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_rpt_w   = $clog2(c_rpt_max + 1);

    logic [c_rpt_w-1:0] r_rpt_cnt;

    assign w_repeat = !w_acc_load && (r_rpt_cnt == c_rpt_w'(1)) &&
                      (r_accepted != c_code_w'(NO_KEY));

    // Counts down to a repeat; releasing or changing key reloads or idles it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rpt_cnt <= '0;
        end else if (w_acc_load) begin
            r_rpt_cnt <= (w_cand != c_code_w'(NO_KEY)) ? c_rpt_w'(REPEAT_DELAY) : '0;
        end else if (r_rpt_cnt == c_rpt_w'(1)) begin
            r_rpt_cnt <= c_rpt_w'(REPEAT_RATE);
        end else if (r_rpt_cnt != '0) begin
            r_rpt_cnt <= r_rpt_cnt - 1'b1;
        end
    end
`else
    logic [31:0] w_unused_rpt;
    assign w_unused_rpt = REPEAT_DELAY ^ REPEAT_RATE;
    assign w_repeat     = 1'b0;
`endif

    assign w_push      = w_press || w_repeat;
    assign w_push_code = w_press ? w_cand : r_accepted;

    keypad_fifo #(
        .WIDTH (c_code_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .push       (w_push),
        .pop        (w_pop),
        .din        (w_push_code),
        .dout       (w_head),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty),
        .empty_next (w_empty_next)
    );

    assign w_rd = CB[3] & DACK & IO_EN;

    always_comb begin
        w_db_live.ovf  = r_ovf;
        w_db_live.code = w_fifo_empty ? 7'h00 : 7'(w_head);
    end

    // Snapshot at strobe start keeps DB steady even if the queue changes mid-strobe.
    assign w_db_out = r_rd_q ? r_db_hold : w_db_live;
    assign w_pop    = r_rd_q && !w_rd && r_hold_valid;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rd_q       <= 1'b0;
            r_db_hold    <= '0;
            r_hold_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_dreq       <= 1'b0;
        end else begin
            r_rd_q <= w_rd;
            if (w_rd && !r_rd_q) begin
                r_db_hold    <= w_db_live;
                r_hold_valid <= !w_fifo_empty;
            end
            if (w_push && w_fifo_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_pop) begin
                r_ovf <= 1'b0;
            end
            r_dreq <= IO_EN & !w_empty_next;
        end
    end

    assign DREQ = r_dreq;
    assign DB   = w_rd ? w_db_out : 8'hzz;

    assign w_unused_bus = ^{AB, CB[2:0]};

endmodule

`default_nettype wire

// File: tb/tb_keypad_dma_ctrl.sv
// ============================================================================
// Module   : tb_keypad_dma_ctrl
// Purpose  : Directed self-checking bench for keypad_dma_ctrl; auto-repeat
//            steps are included when KEYPAD_REPEAT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_dma_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_drv;
    logic       io_en;
    logic       dack;
    logic [3:0] cb_drv;
    logic       dreq;
    wire  [7:0] db_bus;
    wire  [3:0] cb_bus;
    wire  [7:0] ab_bus;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    assign cb_bus = cb_drv;
    assign ab_bus = 8'h00;

    // Undriven DB floats high, so 8'hFF stands for "not driven".
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (db_bus[gi]);
    end

    keypad_dma_ctrl #(
        .NKEYS        (8),
        .DEB_CYCLES   (16),
        .FIFO_DEPTH   (4),
        .REPEAT_DELAY (50),
        .REPEAT_RATE  (20)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .key   (key_drv),
        .IO_EN (io_en),
        .DACK  (dack),
        .DREQ  (dreq),
        .DB    (db_bus),
        .CB    (cb_bus),
        .AB    (ab_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_strobe(input string tag, input logic [7:0] exp);
        dack   = 1'b1;
        cb_drv = 4'h8;
        tick(1);
        check(tag, db_bus, exp);
        tick(2);
        check({tag, "_hold"}, db_bus, exp);
        dack   = 1'b0;
        cb_drv = 4'h0;
        tick(2);
    endtask

    task automatic wait_dreq(input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (dreq) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
`ifdef KEYPAD_REPEAT_EN
        int  t0, t1, t2, t3;
        bit  ok0, ok1, ok2, ok3;
`endif
        rst_n   = 1'b0;
        key_drv = 8'h04;
        io_en   = 1'b1;
        dack    = 1'b0;
        cb_drv  = 4'h0;

        tick(3);
        check("reset_dreq", {7'h0, dreq}, 8'h00);
        check("reset_db_z", db_bus, 8'hFF);
        rst_n = 1'b1;
        tick(1);
        check("post_reset_empty", {7'h0, dreq}, 8'h00);

        // Single press of key 2 -> code 3
        tick(30);
        check("press_dreq", {7'h0, dreq}, 8'h01);
        read_strobe("press_read", 8'h03);
        check("press_drained", {7'h0, dreq}, 8'h00);
        tick(10);
        check("held_no_reevent", {7'h0, dreq}, 8'h00);

        // Bounce never reaches 16 stable cycles
        key_drv = 8'h00;
        tick(25);
        for (int i = 0; i < 8; i++) begin
            key_drv = (i % 2 == 0) ? 8'h01 : 8'h00;
            tick(5);
        end
        check("bounce_no_event", {7'h0, dreq}, 8'h00);
        key_drv = 8'h01;
        tick(30);
        check("bounce_settled", {7'h0, dreq}, 8'h01);
        read_strobe("bounce_read", 8'h01);
        check("bounce_drained", {7'h0, dreq}, 8'h00);

        // Overflow: five presses into a four-entry queue
        key_drv = 8'h00;
        tick(25);
        for (int c = 1; c <= 5; c++) begin
            key_drv = 8'h01 << (c - 1);
            tick(25);
            key_drv = 8'h00;
            tick(25);
        end
        check("ovf_dreq", {7'h0, dreq}, 8'h01);
        read_strobe("ovf_read1", 8'h81);
        read_strobe("ovf_read2", 8'h02);
        read_strobe("ovf_read3", 8'h03);
        read_strobe("ovf_read4", 8'h04);
        check("ovf_drained", {7'h0, dreq}, 8'h00);
        read_strobe("empty_read", 8'h00);

        // Two keys at once encode as no key
        key_drv = 8'h06;
        tick(30);
        check("multikey_none", {7'h0, dreq}, 8'h00);
        key_drv = 8'h00;
        tick(25);

        // IO_EN low hides the queue but keeps capturing
        key_drv = 8'h02;
        tick(30);
        check("ioen_pre_dreq", {7'h0, dreq}, 8'h01);
        io_en = 1'b0;
        tick(1);
        check("ioen_off_dreq", {7'h0, dreq}, 8'h00);
        dack   = 1'b1;
        cb_drv = 4'h8;
        tick(1);
        check("ioen_off_db_z", db_bus, 8'hFF);
        dack   = 1'b0;
        cb_drv = 4'h0;
        tick(2);
        io_en = 1'b1;
        tick(2);
        check("ioen_back_dreq", {7'h0, dreq}, 8'h01);
        read_strobe("ioen_read", 8'h02);
        check("ioen_drained", {7'h0, dreq}, 8'h00);

        // Reset in the middle of a read drops the queue
        key_drv = 8'h00;
        tick(25);
        key_drv = 8'h08;
        tick(30);
        check("midrd_pre_dreq", {7'h0, dreq}, 8'h01);
        dack   = 1'b1;
        cb_drv = 4'h8;
        tick(1);
        check("midrd_db", db_bus, 8'h04);
        rst_n   = 1'b0;
        key_drv = 8'h00;
        tick(2);
        dack   = 1'b0;
        cb_drv = 4'h0;
        rst_n  = 1'b1;
        tick(3);
        check("midrd_rst_dreq", {7'h0, dreq}, 8'h00);
        check("midrd_rst_db_z", db_bus, 8'hFF);
        tick(30);
        check("midrd_stays_empty", {7'h0, dreq}, 8'h00);

`ifdef KEYPAD_REPEAT_EN
        key_drv = 8'h80;
        wait_dreq(40, t0, ok0);
        check("rpt_first_seen", {7'h0, ok0}, 8'h01);
        read_strobe("rpt_read0", 8'h08);
        wait_dreq(60, t1, ok1);
        check("rpt_second_seen", {7'h0, ok1}, 8'h01);
        read_strobe("rpt_read1", 8'h08);
        wait_dreq(30, t2, ok2);
        check("rpt_third_seen", {7'h0, ok2}, 8'h01);
        read_strobe("rpt_read2", 8'h08);
        wait_dreq(30, t3, ok3);
        check("rpt_fourth_seen", {7'h0, ok3}, 8'h01);
        read_strobe("rpt_read3", 8'h08);
        check("rpt_gap_delay", 8'(t1 - t0), 8'd50);
        check("rpt_gap_rate1", 8'(t2 - t1), 8'd20);
        check("rpt_gap_rate2", 8'(t3 - t2), 8'd20);
        key_drv = 8'h00;
        tick(25);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
